// File: rtl/udp_tx.sv
// udp_tx: UDP/IPv4 transmit framer.
// Resolves the destination MAC through the ARP cache, retries through an
// ARP request trigger on a miss, then emits Ethernet II + IPv4 + UDP header
// followed by the payload. Optional short-frame padding to 60 bytes is
// compiled in with `define UDP_TX_PAD_EN.
module udp_tx #(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_006E,
  parameter logic [47:0] LOCAL_MAC  = 48'hABCD_1234_5678,
  parameter logic [15:0] LOCAL_PORT = 16'h1F90,
  parameter logic [15:0] DEST_PORT  = 16'h1F90,
  parameter int unsigned ARP_RETRY  = 3
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [7:0]  udp_tdata_in,
  input  logic        udp_tvalid_in,
  output logic        udp_tready_out,
  input  logic        udp_tlast_in,
  input  logic [31:0] udp_tip_in,
  input  logic [15:0] udp_tlen_in,
  output logic [31:0] arp_query_ip_out,
  output logic        arp_query_valid_out,
  input  logic        arp_query_ready_in,
  input  logic [47:0] arp_response_mac_in,
  input  logic        arp_response_valid_in,
  output logic        arp_response_ready_out,
  input  logic        arp_response_err_in,
  output logic        trig_arp_qvalid_out,
  output logic [31:0] trig_arp_ip_out,
  input  logic        trig_arp_qready_in,
  output logic [7:0]  net_rtrans_data_out,
  output logic        net_rtrans_valid_out,
  input  logic        net_rtrans_ready_in,
  output logic        net_rtrans_last_out,
  output logic        drop_pulse_out
);

  localparam logic [2:0] RETRY_MAX = 3'(ARP_RETRY);
  localparam logic [5:0] HDR_LAST  = 6'd41;

  typedef enum logic [3:0] {
    S_IDLE, S_QUERY, S_RESP, S_TRIG, S_CSUM, S_HDR, S_PAYLOAD,
`ifdef UDP_TX_PAD_EN
    S_PAD,
`endif
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ip_q;
  logic [15:0] len_q;
  logic [47:0] mac_q;
  logic [15:0] id_q;
  logic [2:0]  retry_q;
  logic [5:0]  idx_q;
  logic [31:0] sum_q;
  logic [15:0] csum_q;
  logic        csum_ph_q;

  logic latch_req, latch_mac, inc_retry, clr_retry, hdr_adv, frame_done;
  logic sum_ld, csum_ld;

  logic [15:0]         tot_len, udp_len;
  logic [31:0]         hdr_sum;
  logic [16:0]         fold1;
  logic [15:0]         fold2;
  logic [0:41][7:0]    hdr_b;

`ifdef UDP_TX_PAD_EN
  // payload+pad slot counter, saturating at the slot of frame byte 59
  logic [4:0] pcnt_q;
  logic       pay_adv;
  logic       pad_pend;
  assign pad_pend = (pcnt_q < 5'd17);
`endif

  assign tot_len = len_q + 16'd28;
  assign udp_len = len_q + 16'd8;

  // ones-complement header sum; checksum word itself counts as zero
  assign hdr_sum = 32'h4500 + 32'(tot_len) + 32'(id_q) + 32'h4000 + 32'h4011 +
                   32'(LOCAL_IP[31:16]) + 32'(LOCAL_IP[15:0]) +
                   32'(ip_q[31:16]) + 32'(ip_q[15:0]);
  assign fold1 = 17'(sum_q[15:0]) + 17'(sum_q[31:16]);
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

  assign hdr_b = {mac_q, LOCAL_MAC, 16'h0800, 8'h45, 8'h00, tot_len, id_q,
                  8'h40, 8'h00, 8'h40, 8'h11, csum_q, LOCAL_IP, ip_q,
                  LOCAL_PORT, DEST_PORT, udp_len, 16'h0000};

  assign arp_query_ip_out = ip_q;
  assign trig_arp_ip_out  = ip_q;

  // state register
  always_ff @(posedge logic_clk or negedge logic_rst) begin
    if (!logic_rst) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // next state, handshake outputs and datapath strobes
  always_comb begin
    state_d                = state_q;
    udp_tready_out         = 1'b0;
    arp_query_valid_out    = 1'b0;
    arp_response_ready_out = 1'b0;
    trig_arp_qvalid_out    = 1'b0;
    net_rtrans_valid_out   = 1'b0;
    net_rtrans_data_out    = 8'h00;
    net_rtrans_last_out    = 1'b0;
    drop_pulse_out         = 1'b0;
    latch_req  = 1'b0;
    latch_mac  = 1'b0;
    inc_retry  = 1'b0;
    clr_retry  = 1'b0;
    hdr_adv    = 1'b0;
    frame_done = 1'b0;
    sum_ld     = 1'b0;
    csum_ld    = 1'b0;
`ifdef UDP_TX_PAD_EN
    pay_adv    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (udp_tvalid_in) begin
          latch_req = 1'b1;
          state_d   = S_QUERY;
        end
      end
      S_QUERY: begin
        arp_query_valid_out = 1'b1;
        if (arp_query_ready_in) state_d = S_RESP;
      end
      S_RESP: begin
        arp_response_ready_out = 1'b1;
        if (arp_response_valid_in) begin
          if (!arp_response_err_in) begin
            latch_mac = 1'b1;
            state_d   = S_CSUM;
          end else if (retry_q < RETRY_MAX) begin
            state_d = S_TRIG;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_TRIG: begin
        trig_arp_qvalid_out = 1'b1;
        if (trig_arp_qready_in) begin
          inc_retry = 1'b1;
          state_d   = S_QUERY;
        end
      end
      S_CSUM: begin
        if (!csum_ph_q) sum_ld = 1'b1;
        else begin
          csum_ld = 1'b1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        net_rtrans_valid_out = 1'b1;
        net_rtrans_data_out  = hdr_b[idx_q];
        if (net_rtrans_ready_in) begin
          hdr_adv = 1'b1;
          if (idx_q == HDR_LAST) state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        net_rtrans_valid_out = udp_tvalid_in;
        net_rtrans_data_out  = udp_tdata_in;
        udp_tready_out       = net_rtrans_ready_in;
`ifdef UDP_TX_PAD_EN
        net_rtrans_last_out  = udp_tlast_in && !pad_pend;
`else
        net_rtrans_last_out  = udp_tlast_in;
`endif
        if (udp_tvalid_in && net_rtrans_ready_in) begin
`ifdef UDP_TX_PAD_EN
          pay_adv = 1'b1;
          if (udp_tlast_in) begin
            if (pad_pend) state_d = S_PAD;
            else begin
              frame_done = 1'b1;
              state_d    = S_IDLE;
            end
          end
`else
          if (udp_tlast_in) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end
`endif
        end
      end
`ifdef UDP_TX_PAD_EN
      S_PAD: begin
        net_rtrans_valid_out = 1'b1;
        net_rtrans_last_out  = !pad_pend;
        if (net_rtrans_ready_in) begin
          pay_adv = 1'b1;
          if (!pad_pend) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
`endif
      S_DROP: begin
        udp_tready_out = 1'b1;
        if (udp_tvalid_in && udp_tlast_in) begin
          drop_pulse_out = 1'b1;
          clr_retry      = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // packet context, retry/identification counters, checksum pipeline
  always_ff @(posedge logic_clk or negedge logic_rst) begin
    if (!logic_rst) begin
      ip_q      <= '0;
      len_q     <= '0;
      mac_q     <= '0;
      id_q      <= '0;
      retry_q   <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      csum_q    <= '0;
      csum_ph_q <= 1'b0;
    end else begin
      if (latch_req) begin
        ip_q  <= udp_tip_in;
        len_q <= udp_tlen_in;
      end
      if (latch_mac) mac_q <= arp_response_mac_in;
      if (clr_retry || frame_done) retry_q <= '0;
      else if (inc_retry)          retry_q <= retry_q + 3'd1;
      if (frame_done) id_q <= id_q + 16'd1;
      if (sum_ld) begin
        sum_q     <= hdr_sum;
        csum_ph_q <= 1'b1;
      end
      if (csum_ld) begin
        csum_q    <= ~fold2;
        csum_ph_q <= 1'b0;
      end
      if (hdr_adv) idx_q <= (idx_q == HDR_LAST) ? 6'd0 : idx_q + 6'd1;
    end
  end

`ifdef UDP_TX_PAD_EN
  // counts payload then pad slots; frame byte 59 sits at slot 17
  always_ff @(posedge logic_clk or negedge logic_rst) begin
    if (!logic_rst)                      pcnt_q <= '0;
    else if (latch_req)                  pcnt_q <= '0;
    else if (pay_adv && pcnt_q < 5'd17)  pcnt_q <= pcnt_q + 5'd1;
  end
`endif

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: randomized bench for udp_tx with a frame-level reference model.
module tb_udp_tx;

  logic        logic_clk = 1'b0;
  logic        logic_rst = 1'b0;
  logic [7:0]  udp_tdata_in;
  logic        udp_tvalid_in, udp_tlast_in, udp_tready_out;
  logic [31:0] udp_tip_in;
  logic [15:0] udp_tlen_in;
  logic [31:0] arp_query_ip_out;
  logic        arp_query_valid_out, arp_query_ready_in;
  logic [47:0] arp_response_mac_in;
  logic        arp_response_valid_in, arp_response_ready_out, arp_response_err_in;
  logic        trig_arp_qvalid_out, trig_arp_qready_in;
  logic [31:0] trig_arp_ip_out;
  logic [7:0]  net_rtrans_data_out;
  logic        net_rtrans_valid_out, net_rtrans_ready_in, net_rtrans_last_out;
  logic        drop_pulse_out;

  udp_tx dut (
    .logic_clk(logic_clk), .logic_rst(logic_rst),
    .udp_tdata_in(udp_tdata_in), .udp_tvalid_in(udp_tvalid_in),
    .udp_tready_out(udp_tready_out), .udp_tlast_in(udp_tlast_in),
    .udp_tip_in(udp_tip_in), .udp_tlen_in(udp_tlen_in),
    .arp_query_ip_out(arp_query_ip_out), .arp_query_valid_out(arp_query_valid_out),
    .arp_query_ready_in(arp_query_ready_in),
    .arp_response_mac_in(arp_response_mac_in), .arp_response_valid_in(arp_response_valid_in),
    .arp_response_ready_out(arp_response_ready_out), .arp_response_err_in(arp_response_err_in),
    .trig_arp_qvalid_out(trig_arp_qvalid_out), .trig_arp_ip_out(trig_arp_ip_out),
    .trig_arp_qready_in(trig_arp_qready_in),
    .net_rtrans_data_out(net_rtrans_data_out), .net_rtrans_valid_out(net_rtrans_valid_out),
    .net_rtrans_ready_in(net_rtrans_ready_in), .net_rtrans_last_out(net_rtrans_last_out),
    .drop_pulse_out(drop_pulse_out)
  );

  always #5 logic_clk = ~logic_clk;

  int n_cmp = 0;
  int n_err = 0;

  // stimulus / observation state
  logic [7:0]  pl[$];
  logic [7:0]  outq[$];
  logic [7:0]  exp_q[$];
  int          lasts[$];
  int          pl_idx, drops, trigs, queries, lat, hold_err, tready_err, misses_left;
  bit          pkt_active, rnd_rdy, seen, exp_drop;
  bit          prev_v, prev_r;
  logic [7:0]  prev_d;
  logic [31:0] q_ip, t_ip;
  logic [47:0] resp_mac;
  logic [15:0] exp_id;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void pushn(input logic [47:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
  endfunction

  // expected frame built from the field layout with plain arithmetic
  function automatic void build_exp(input logic [47:0] mac, input logic [31:0] ip,
                                    input int n, input logic [15:0] id);
    logic [31:0]  lip;
    logic [47:0]  lmac;
    logic [15:0]  w[10];
    logic [15:0]  tl, ul, ck;
    int unsigned  s;
    lip  = 32'hC0A8_006E;
    lmac = 48'hABCD_1234_5678;
    tl = 16'(n + 28);
    ul = 16'(n + 8);
    w = '{16'h4500, tl, id, 16'h4000, 16'h4011, 16'h0000,
          lip[31:16], lip[15:0], ip[31:16], ip[15:0]};
    s = 0;
    foreach (w[i]) s += w[i];
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    ck = ~s[15:0];
    exp_q.delete();
    pushn(mac, 6); pushn(lmac, 6); pushn(48'h0800, 2);
    pushn(48'h4500, 2); pushn(tl, 2); pushn(id, 2);
    pushn(48'h4000, 2); pushn(48'h4011, 2); pushn(ck, 2);
    pushn(lip, 4); pushn(ip, 4);
    pushn(48'h1F90, 2); pushn(48'h1F90, 2); pushn(ul, 2); pushn(48'h0000, 2);
    foreach (pl[i]) exp_q.push_back(pl[i]);
`ifdef UDP_TX_PAD_EN
    while (exp_q.size() < 60) exp_q.push_back(8'h00);
`endif
  endfunction

  task automatic drive();
    udp_tvalid_in       = pkt_active && (pl_idx < pl.size());
    udp_tdata_in        = udp_tvalid_in ? pl[pl_idx] : 8'h00;
    udp_tlast_in        = udp_tvalid_in && (pl_idx == pl.size() - 1);
    arp_response_err_in = (misses_left > 0);
    arp_response_mac_in = resp_mac;
    net_rtrans_ready_in = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // sample everything on the falling edge, drive just after the rising edge
  task automatic tick();
    @(negedge logic_clk);
    if (udp_tvalid_in && !seen) begin
      if (net_rtrans_valid_out) seen = 1'b1;
      else lat++;
    end
    if (prev_v && !prev_r && (!net_rtrans_valid_out || net_rtrans_data_out !== prev_d))
      hold_err++;
    prev_v = net_rtrans_valid_out;
    prev_r = net_rtrans_ready_in;
    prev_d = net_rtrans_data_out;
    if (udp_tready_out && !exp_drop && outq.size() < 42) tready_err++;
    if (net_rtrans_valid_out && net_rtrans_ready_in) begin
      outq.push_back(net_rtrans_data_out);
      if (net_rtrans_last_out) lasts.push_back(outq.size() - 1);
    end
    if (drop_pulse_out) drops++;
    if (udp_tvalid_in && udp_tready_out) pl_idx++;
    if (arp_response_valid_in && arp_response_ready_out && misses_left > 0) misses_left--;
    if (arp_query_valid_out && arp_query_ready_in) begin
      queries++;
      q_ip = arp_query_ip_out;
    end
    if (trig_arp_qvalid_out && trig_arp_qready_in) begin
      trigs++;
      t_ip = trig_arp_ip_out;
    end
    @(posedge logic_clk);
    #1;
    drive();
  endtask

  task automatic start_pkt(input logic [47:0] mac, input logic [31:0] ip, input int n,
                           input int misses, input bit rnd, input bit ramp);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(ramp ? 8'(i) : 8'($urandom));
    outq.delete(); lasts.delete();
    pl_idx = 0; drops = 0; trigs = 0; queries = 0; lat = 0;
    hold_err = 0; tready_err = 0; seen = 1'b0; prev_v = 1'b0;
    resp_mac = mac; misses_left = misses; rnd_rdy = rnd; exp_drop = (misses > 3);
    udp_tip_in = ip;
    udp_tlen_in = 16'(n);
    pkt_active = 1'b1;
    drive();
  endtask

  task automatic run_pkt(input string tag, input logic [47:0] mac, input logic [31:0] ip,
                         input int n, input int misses, input bit rnd, input bit ramp);
    int guard;
    start_pkt(mac, ip, n, misses, rnd, ramp);
    guard = 0;
    while (!(pl_idx == n && (lasts.size() > 0 || drops > 0)) && guard < 4000) begin
      tick();
      guard++;
    end
    chk({tag, "_done"}, guard < 4000, 1);
    pkt_active = 1'b0;
    repeat (3) tick();
    chk({tag, "_query_ip"}, q_ip, ip);
    chk({tag, "_hold"}, hold_err, 0);
    chk({tag, "_tready"}, tready_err, 0);
    chk({tag, "_consumed"}, pl_idx, n);
    if (!exp_drop) begin
      build_exp(mac, ip, n, exp_id);
      exp_id = exp_id + 16'd1;
      chk({tag, "_len"}, outq.size(), exp_q.size());
      for (int i = 0; i < outq.size() && i < exp_q.size(); i++)
        chk($sformatf("%s_byte%0d", tag, i), outq[i], exp_q[i]);
      chk({tag, "_last_cnt"}, lasts.size(), 1);
      if (lasts.size() > 0) chk({tag, "_last_pos"}, lasts[0], exp_q.size() - 1);
      chk({tag, "_drop"}, drops, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    udp_tdata_in = 8'h00; udp_tvalid_in = 1'b0; udp_tlast_in = 1'b0;
    udp_tip_in = '0; udp_tlen_in = '0;
    arp_query_ready_in = 1'b1; arp_response_valid_in = 1'b1;
    arp_response_err_in = 1'b0; arp_response_mac_in = '0;
    trig_arp_qready_in = 1'b1; net_rtrans_ready_in = 1'b1;
    pkt_active = 1'b0; misses_left = 0; rnd_rdy = 1'b0; exp_id = 16'h0000;
    resp_mac = '0; q_ip = '0; t_ip = '0; exp_drop = 1'b0;
    pl_idx = 0; prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00; seen = 1'b0;
    repeat (3) @(posedge logic_clk);
    #1;
    // reset state
    chk("rst_valid", net_rtrans_valid_out, 0);
    chk("rst_last", net_rtrans_last_out, 0);
    chk("rst_data", net_rtrans_data_out, 0);
    chk("rst_tready", udp_tready_out, 0);
    chk("rst_qvalid", arp_query_valid_out, 0);
    chk("rst_qip", arp_query_ip_out, 0);
    chk("rst_rready", arp_response_ready_out, 0);
    chk("rst_trig", trig_arp_qvalid_out, 0);
    chk("rst_drop", drop_pulse_out, 0);
    logic_rst = 1'b1;
    tick();

    // directed cache hit, ramp payload
    run_pkt("hit32", 48'h0011_2233_4455, 32'hC0A8_0001, 32, 0, 1'b0, 1'b1);
    chk("hit32_latency", lat, 5);
    if (outq.size() >= 40) begin
      chk("hit32_totlen", {outq[16], outq[17]}, 16'h003C);
      chk("hit32_udplen", {outq[38], outq[39]}, 16'h0028);
      chk("hit32_id", {outq[18], outq[19]}, 16'h0000);
    end

    // back-to-back: identification 1
    run_pkt("b2b", 48'h0A0B_0C0D_0E0F, $urandom, 20, 0, 1'b0, 1'b0);
    if (outq.size() >= 20) chk("b2b_id", {outq[18], outq[19]}, 16'h0001);

    // one miss then hit
    run_pkt("miss1", 48'h1122_3344_5566, 32'hC0A8_0042, 25, 1, 1'b0, 1'b0);
    chk("miss1_trigs", trigs, 1);
    chk("miss1_queries", queries, 2);
    chk("miss1_trig_ip", t_ip, 32'hC0A8_0042);

    // four misses: dropped
    run_pkt("drop", 48'h1122_3344_5566, 32'hC0A8_0099, 12, 4, 1'b0, 1'b0);
    chk("drop_pulse", drops, 1);
    chk("drop_frame", outq.size(), 0);
    chk("drop_trigs", trigs, 3);
    chk("drop_queries", queries, 4);

    // random stalls and lengths
    for (int k = 0; k < 6; k++)
      run_pkt($sformatf("rnd%0d", k), {$urandom, 16'($urandom)}, $urandom,
              $urandom_range(1, 80), 0, 1'b1, 1'b0);

    // short payload
    run_pkt("short4", 48'h0011_2233_4455, 32'hC0A8_0002, 4, 0, 1'b1, 1'b0);
`ifdef UDP_TX_PAD_EN
    chk("short4_frame", outq.size(), 60);
`else
    chk("short4_frame", outq.size(), 46);
`endif
    if (outq.size() >= 40) chk("short4_udplen", {outq[38], outq[39]}, 16'h000C);

    // reset during payload byte 10
    begin
      int guard;
      start_pkt(48'h0011_2233_4455, 32'hC0A8_0003, 30, 0, 1'b0, 1'b0);
      guard = 0;
      while (pl_idx < 10 && guard < 1000) begin
        tick();
        guard++;
      end
      chk("mid_reached", pl_idx, 10);
      chk("mid_pre_valid", net_rtrans_valid_out, 1);
      logic_rst = 1'b0;
      pkt_active = 1'b0;
      drive();
      #1;
      chk("mid_valid", net_rtrans_valid_out, 0);
      chk("mid_last", net_rtrans_last_out, 0);
      chk("mid_data", net_rtrans_data_out, 0);
      chk("mid_tready", udp_tready_out, 0);
      chk("mid_qvalid", arp_query_valid_out, 0);
      tick();
      logic_rst = 1'b1;
      tick();
      exp_id = 16'h0000;
    end
    run_pkt("postrst", 48'h0022_4466_88AA, 32'hC0A8_0004, 24, 0, 1'b0, 1'b0);
    if (outq.size() >= 20) chk("postrst_id", {outq[18], outq[19]}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/udp_tx.md
# udp_tx

UDP/IPv4 transmit framer, the transmit-side counterpart of the receive frame splitter in the network layer. It accepts a byte-wide UDP payload stream with destination IP and payload length. It resolves the destination MAC through the ARP cache query port, triggering an ARP request on a miss. It emits a complete Ethernet II + IPv4 + UDP frame on the `net_rtrans_*` stream, which the network top muxes to the MAC; the MAC adds preamble and FCS.

## Interface
- `LOCAL_IP`, 32'hC0A8_006E, source IP address.
- `LOCAL_MAC`, 48'hABCD_1234_5678, source MAC address.
- `LOCAL_PORT`, 16'h1F90, UDP source port.
- `DEST_PORT`, 16'h1F90, UDP destination port.
- `ARP_RETRY`, 3, ARP miss retries before the packet is dropped.

- `logic_clk` in 1: single clock.
- `logic_rst` in 1: asynchronous, active-low reset.
- `udp_tdata_in` in 8: payload byte.
- `udp_tvalid_in` in 1: payload valid.
- `udp_tready_out` out 1: payload accepted.
- `udp_tlast_in` in 1: last payload byte.
- `udp_tip_in` in 32: destination IP; held stable while `udp_tvalid_in` is high.
- `udp_tlen_in` in 16: payload length in bytes (1..1472); held stable like `udp_tip_in`.
- `arp_query_ip_out` out 32, `arp_query_valid_out` out 1, `arp_query_ready_in` in 1: cache query.
- `arp_response_mac_in` in 48, `arp_response_valid_in` in 1, `arp_response_ready_out` out 1, `arp_response_err_in` in 1: cache response; err means miss.
- `trig_arp_qvalid_out` out 1, `trig_arp_ip_out` out 32, `trig_arp_qready_in` in 1: ARP request trigger; ready means the query has been answered.
- `net_rtrans_data_out` out 8, `net_rtrans_valid_out` out 1, `net_rtrans_ready_in` in 1, `net_rtrans_last_out` out 1: frame out.
- `drop_pulse_out` out 1: one-cycle pulse when a packet is discarded.

## Operation
- States: IDLE, QUERY, RESP, TRIG, CSUM, HDR, PAYLOAD, PAD, DROP.
- IDLE → QUERY on `udp_tvalid_in`.
  - Latch `udp_tip_in` and `udp_tlen_in`.
  - Do not consume the byte.
- QUERY: `arp_query_valid_out`=1 with the latched IP. Go to RESP on query ready.
- RESP: `arp_response_ready_out`=1. On response valid:
  - err=0: latch the MAC, go to CSUM.
  - err=1 and retries < `ARP_RETRY`: go to TRIG.
  - err=1 and retries exhausted: go to DROP.
- TRIG: `trig_arp_qvalid_out`=1 until `trig_arp_qready_in`, then increment the retry count and go to QUERY.
- CSUM: 2 cycles.
  - Cycle 1 registers the 32-bit sum of the ten IPv4 header 16-bit words (checksum field = 0).
  - Cycle 2 folds carries twice and inverts to give the 16-bit checksum.
- HDR: 42 bytes, index counter 0..41, advances on valid&ready.
  - Destination MAC; `LOCAL_MAC`; EtherType 0x0800.
  - 0x45, 0x00; total length = len+28; identification (16-bit counter).
  - 0x40, 0x00; TTL 0x40; protocol 0x11; checksum.
  - `LOCAL_IP`; destination IP.
  - `LOCAL_PORT`; `DEST_PORT`; UDP length = len+8; UDP checksum 0x0000.
  - All fields big-endian.
- PAYLOAD: combinational pass-through.
  - valid out = `udp_tvalid_in`, `udp_tready_out` = `net_rtrans_ready_in`, data = input byte.
  - last = `udp_tlast_in`, except when padding is pending (see Configuration).
  - Leaves on the tlast handshake.
- On frame completion: identification increments with wrap 0xFFFF→0x0000, retry count clears, go to IDLE.
- DROP: `udp_tready_out`=1 and payload is discarded through tlast. `drop_pulse_out` fires on the tlast beat. Go to IDLE.
- The frame always ends at `udp_tlast_in`. A mismatch with `udp_tlen_in` is not corrected; header lengths always come from `udp_tlen_in`.

## Timing
- Reset values: all valid/ready/last outputs 0, data/IP outputs 0, identification 0, retry count 0, state IDLE.
- Reset assertion mid-frame aborts immediately; no last is emitted.
- `udp_tready_out` is 0 outside PAYLOAD and DROP.
- First header byte appears at cycle 1 (IDLE→QUERY) + query wait + response wait + 2 (CSUM) after `udp_tvalid_in`. Zero-wait cache: header valid 5 cycles after `udp_tvalid_in`.
- Valid/data are held stable while ready is low in HDR and PAD.
- No bubble between header byte 41 and the first payload byte when the input is valid.
- Back-to-back packets: IDLE is entered for at least 1 cycle.

## Configuration
- `UDP_TX_PAD_EN` defined:
  - Payloads shorter than 18 bytes are followed by PAD with 0x00 bytes up to a 60-byte frame.
  - `net_rtrans_last_out` is on the final pad byte; tlast from the payload is not forwarded.
  - Header lengths remain unpadded values.
- Not defined: no PAD state; frames may be shorter than 60 bytes and the MAC pads.

## Test plan
- Cache hit, MAC 48'h0011_2233_4455, IP C0A8_0001, 32-byte payload 0x00..0x1F → 74-byte frame, total length 0x003C, UDP length 0x0028, IP checksum correct per reference model, last on byte 73.
- Two packets back-to-back → identification 0x0000 then 0x0001. Preset 0xFFFF → next 0x0000.
- Miss once then hit → one TRIG handshake, second query, frame sent normally. Four consecutive misses → DROP, payload fully consumed, `drop_pulse_out` one cycle, no frame output.
- Random `net_rtrans_ready_in` (50%) during HDR and PAYLOAD → byte sequence identical to the no-stall case, no duplicated or lost bytes.
- `UDP_TX_PAD_EN`, 4-byte payload → 60-byte frame, bytes 46..59 = 0x00, UDP length 0x000C. Without the macro → 46-byte frame.
- Reset pulse during PAYLOAD byte 10 → all outputs return to 0 the same cycle, next packet framed correctly with identification 0.
